// File: rtl/nvdla_core_reset_req.sv
// Soft core-reset sequencer: drains the core, drives core_reset_rstn low, confirms it
// through the synchronizer feedback, holds it, releases it and confirms the release.
module nvdla_core_reset_req #(
    parameter int unsigned DRAIN_TIMEOUT = 1024,
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned ACK_TIMEOUT   = 256
) (
    input  logic       nvdla_clk,
    input  logic       dla_reset_rstn,
    input  logic       sw_reset_req,
    input  logic       core_idle,
    input  logic       synced_rstn,
    output logic       core_reset_rstn,
    output logic       reset_busy,
    output logic       reset_done,
    output logic [1:0] reset_status
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_ASSERT  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RELEASE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_TIMEOUT - 32'd1);
    localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYCLES - 32'd1);
    localparam logic [15:0] ACK_LAST   = 16'(ACK_TIMEOUT - 32'd1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] cnt_r;
    logic [1:0]  status_nxt_s;
    logic        rstn_nxt_s;
    logic        busy_nxt_s;
    logic        done_nxt_s;

    // Next-state and sticky status; each wait is bounded by the shared counter.
    always_comb begin
        state_nxt_s  = state_r;
        status_nxt_s = reset_status;
        case (state_r)
            ST_IDLE: begin
                if (sw_reset_req) begin
                    state_nxt_s  = ST_DRAIN;
                    status_nxt_s = 2'b00;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (core_idle) begin
                    state_nxt_s = ST_ASSERT;
                end else if (cnt_r == DRAIN_LAST) begin
                    state_nxt_s     = ST_ASSERT;
                    status_nxt_s[0] = 1'b1;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_ASSERT: begin
                if (!synced_rstn) begin
                    state_nxt_s = ST_HOLD;
                end else if (cnt_r == ACK_LAST) begin
                    state_nxt_s     = ST_HOLD;
                    status_nxt_s[1] = 1'b1;
                end else begin
                    state_nxt_s = ST_ASSERT;
                end
            end
            ST_HOLD: begin
                if (cnt_r == HOLD_LAST) begin
                    state_nxt_s = ST_RELEASE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_RELEASE: begin
                if (synced_rstn) begin
                    state_nxt_s = ST_DONE;
                end else if (cnt_r == ACK_LAST) begin
                    state_nxt_s     = ST_DONE;
                    status_nxt_s[1] = 1'b1;
                end else begin
                    state_nxt_s = ST_RELEASE;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registers change on the entry edge.
    always_comb begin
        rstn_nxt_s = 1'b1;
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_DRAIN:   busy_nxt_s = 1'b1;
            ST_ASSERT: begin
                busy_nxt_s = 1'b1;
                rstn_nxt_s = 1'b0;
            end
            ST_HOLD: begin
                busy_nxt_s = 1'b1;
                rstn_nxt_s = 1'b0;
            end
            ST_RELEASE: busy_nxt_s = 1'b1;
            ST_DONE:    done_nxt_s = 1'b1;
            default: begin
                rstn_nxt_s = 1'b1;
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // State, saturating counter (cleared on every state change) and registered outputs.
    always_ff @(posedge nvdla_clk or negedge dla_reset_rstn) begin
        if (!dla_reset_rstn) begin
            state_r         <= ST_IDLE;
            cnt_r           <= 16'd0;
            core_reset_rstn <= 1'b1;
            reset_busy      <= 1'b0;
            reset_done      <= 1'b0;
            reset_status    <= 2'b00;
        end else begin
            state_r <= state_nxt_s;
            if (state_nxt_s != state_r) begin
                cnt_r <= 16'd0;
            end else if (cnt_r != 16'hFFFF) begin
                cnt_r <= cnt_r + 16'd1;
            end else begin
                cnt_r <= cnt_r;
            end
            core_reset_rstn <= rstn_nxt_s;
            reset_busy      <= busy_nxt_s;
            reset_done      <= done_nxt_s;
            reset_status    <= status_nxt_s;
        end
    end

endmodule
